uartm_rx: RTL and testbench
===========================

UARTM_RX -- requirements
Module: uartm_rx

Interface
REQ-001 SHALL have port hclk, input, 1, clock.
REQ-002 SHALL have port hresetn, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port RX, input, 1, asynchronous serial line, idle high.
REQ-004 SHALL have port uartm_baud, input, 32, bit period minus one in hclk cycles; minimum legal value 4.
REQ-005 SHALL have port uartm_ctl, input, 32, with fields:
- [1:0] word width: 00=8, 01=16, 10=32, 11=8.
- [2] parity enable.
- [3] parity mode: 1=even, 0=odd.
REQ-006 SHALL have port rx_data, output, 32, received word, right-justified, upper bits zero.
REQ-007 SHALL have port rx_valid, output, 1, word available.
REQ-008 SHALL have port rx_ready, input, 1, consumer accepts word.
REQ-009 SHALL have port parity_err, output, 1, parity mismatch, qualified by rx_valid.
REQ-010 SHALL have port frame_err, output, 1, stop bit sampled low, qualified by rx_valid.
REQ-011 SHALL have port overrun_err, output, 1, one-cycle pulse when a completed word is dropped.

Function
REQ-012 SHALL pass RX through a 2-flop synchronizer (reset value 1) before any use; all timing below is relative to the synchronized line rxs.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START on a 1->0 edge of rxs; SHALL latch uartm_baud and uartm_ctl[3:0] at this point; input changes mid-frame SHALL be ignored.
REQ-015 START: after half = latched_baud>>1 cycles, sample rxs:
- 0 -> DATA.
- 1 -> IDLE (glitch; no output, no error).
REQ-016 DATA/PARITY/STOP: sample once every latched_baud+1 cycles after the start-bit sample point.
REQ-017 DATA: sample N bits (N from ctl[1:0]), LSB first, into shift register bit index bit_cnt; bit_cnt SHALL be 6 bits and clear on entry to START.
REQ-018 After bit N-1, the FSM SHALL go to PARITY if ctl[2]=1, else to STOP.
REQ-019 Parity expected bit SHALL be ~(^data ^ ctl[3]); parity_err = sampled bit != expected; with parity disabled, parity_err SHALL be 0.
REQ-020 STOP: sampled 0 sets frame_err; the data SHALL still be delivered.
REQ-021 After a low stop sample, the FSM SHALL remain in STOP until rxs=1 before returning to IDLE.
REQ-022 The cycle after the stop sample, rx_valid SHALL rise with rx_data/parity_err/frame_err if rx_valid is currently 0 or being consumed this cycle (rx_valid & rx_ready).
REQ-023 Otherwise, the new word SHALL be discarded, the held word SHALL stay unchanged, and overrun_err SHALL pulse for 1 cycle.
REQ-024 rx_valid SHALL stay high with stable rx_data and flags until the cycle rx_valid & rx_ready, then clear on the next edge unless REQ-022 reloads it in that same cycle.
REQ-025 A new start edge SHALL be detectable in the cycle after return to IDLE (back-to-back frames, one stop bit).

Reset
REQ-026 On hresetn low, the following SHALL reset:
- FSM -> IDLE.
- Synchronizer -> 1.
- Counters -> 0.
- rx_data -> 0; rx_valid, parity_err, frame_err, overrun_err -> 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no output; after release, the FSM SHALL wait for a fresh 1->0 edge.

Configuration
REQ-028 With UARTM_RX_MAJORITY_EN defined, each sample (start, data, parity, stop) SHALL be the 2-of-3 majority of rxs at sample point -1, 0, +1 cycle.
REQ-029 Without UARTM_RX_MAJORITY_EN, each sample SHALL be the single value of rxs at the sample point; sample-point timing SHALL be identical in both builds.

Structure
REQ-030 A shared package uartm_pkg SHALL hold:
- FSM state encoding.
- Width-code constants (W8=2'b00, W16=2'b01, W32=2'b10).
- A width-decode function returning N.
- ctl bit-position constants shared with the transmitter.
REQ-031 The synchronizer plus majority sampler SHALL be one sub-module, uartm_rx_sample; the FSM, shifter and output register SHALL live in uartm_rx.

Verification
REQ-032 Bench SHALL cover, with baud=9, ctl=0, rx_ready=1: frame 0xA5 -> single rx_valid, rx_data=0x000000A5, no errors.
REQ-033 Bench SHALL cover, with ctl=0x0E (32-bit, even parity): word 0x12345678 with correct parity -> rx_data=0x12345678, parity_err=0; same word with flipped parity bit -> parity_err=1.
REQ-034 Bench SHALL cover, with 8-bit width: a 3-cycle low glitch on RX -> no rx_valid; stop bit driven low -> rx_valid with frame_err=1, and the next frame is not accepted until RX returns high.
REQ-035 Bench SHALL cover, with rx_ready=0: two back-to-back frames 0x11, 0x22 -> rx_data stays 0x11 and overrun_err pulses once; then rx_ready=1 -> 0x11 consumed, rx_valid=0.
REQ-036 Bench SHALL cover: hresetn asserted during data bit 4 of a frame -> all outputs 0; the following clean frame 0x3C is received correctly.
REQ-037 Bench SHALL cover, with UARTM_RX_MAJORITY_EN defined: a 1-cycle inverted pulse on a data bit centre of 0x00 -> rx_data=0x00; without the macro, the same stimulus -> the corresponding bit is 1.

Source files
------------

// File: rtl/uartm_pkg.sv
// Shared UART definitions: receiver FSM encoding, width codes, uartm_ctl bit positions.
package uartm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;

  localparam int CTL_WIDTH_LSB = 0;
  localparam int CTL_PAR_EN    = 2;
  localparam int CTL_PAR_EVEN  = 3;

  function automatic logic [5:0] width_bits(input logic [1:0] code);
    case (code)
      W16:     return 6'd16;
      W32:     return 6'd32;
      default: return 6'd8;
    endcase
  endfunction

endpackage

// File: rtl/uartm_rx_sample.sv
// RX synchronizer and bit sampler; optional 2-of-3 majority vote when
// UARTM_RX_MAJORITY_EN is defined.
module uartm_rx_sample (
  input  logic hclk,
  input  logic hresetn,
  input  logic rx,
  output logic line,
  output logic line_prev,
  output logic sample_bit
);

  logic sync1;
  logic rxs;
  logic rxs_d;
  logic rxs_d2;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sync1  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      sync1  <= rx;
      rxs    <= sync1;
      rxs_d  <= rxs;
      rxs_d2 <= rxs_d;
    end
  end

  // The FSM runs on rxs delayed by one so the +1 neighbour exists at the
  // sample point; both builds see the same delayed line and timing.
  assign line      = rxs_d;
  assign line_prev = rxs_d2;

`ifdef UARTM_RX_MAJORITY_EN
  assign sample_bit = (rxs & rxs_d) | (rxs & rxs_d2) | (rxs_d & rxs_d2);
`else
  assign sample_bit = rxs_d;
`endif

endmodule

// File: rtl/uartm_rx.sv
// UART receiver: start detect, data/parity/stop sampling, one-word output
// holding register with overrun detection. Build option: UARTM_RX_MAJORITY_EN.
module uartm_rx
  import uartm_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        RX,
  input  logic [31:0] uartm_baud,
  input  logic [31:0] uartm_ctl,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun_err
);

  rx_state_t   state_q, state_nxt;
  logic [31:0] cnt_q;
  logic [31:0] baud_q;
  logic [3:0]  ctl_q;
  logic [5:0]  bit_cnt_q;
  logic [5:0]  n_bits;
  logic [31:0] shreg_q;
  logic        par_err_q;
  logic        stop_low_q;

  logic line, line_prev, sample_bit;
  logic tick, frame_go, cnt_run, shift_en, par_en, stop_en;

  logic unused_ctl;
  assign unused_ctl = ^uartm_ctl[31:4];

  uartm_rx_sample u_sample (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .rx         (RX),
    .line       (line),
    .line_prev  (line_prev),
    .sample_bit (sample_bit)
  );

  assign n_bits = width_bits(ctl_q[CTL_WIDTH_LSB +: 2]);
  assign tick   = (cnt_q == 32'd0);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    frame_go  = 1'b0;
    cnt_run   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_prev && !line) begin
          frame_go  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        cnt_run = 1'b1;
        if (tick) state_nxt = sample_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        cnt_run = 1'b1;
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt_q == n_bits - 6'd1)
            state_nxt = ctl_q[CTL_PAR_EN] ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        cnt_run = 1'b1;
        if (tick) begin
          par_en    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        // A low stop bit parks here until the line idles again.
        if (stop_low_q) begin
          if (line) state_nxt = ST_IDLE;
        end else begin
          cnt_run = 1'b1;
          if (tick) begin
            stop_en = 1'b1;
            if (sample_bit) state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_q      <= '0;
      baud_q     <= '0;
      ctl_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      stop_low_q <= 1'b0;
    end else begin
      if (frame_go) begin
        baud_q     <= uartm_baud;
        ctl_q      <= uartm_ctl[3:0];
        cnt_q      <= uartm_baud >> 1;
        bit_cnt_q  <= '0;
        shreg_q    <= '0;
        par_err_q  <= 1'b0;
        stop_low_q <= 1'b0;
      end else if (cnt_run) begin
        cnt_q <= tick ? baud_q : cnt_q - 32'd1;
      end
      if (shift_en) begin
        shreg_q[bit_cnt_q[4:0]] <= sample_bit;
        bit_cnt_q               <= bit_cnt_q + 6'd1;
      end
      if (par_en)
        par_err_q <= (sample_bit != ~(^shreg_q ^ ctl_q[CTL_PAR_EVEN]));
      if (stop_en && !sample_bit)
        stop_low_q <= 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (stop_en) begin
        if (!rx_valid || rx_ready) begin
          rx_valid   <= 1'b1;
          rx_data    <= shreg_q;
          parity_err <= par_err_q;
          frame_err  <= !sample_bit;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uartm_rx.sv
// Scoreboard bench for uartm_rx: expected words queued as frames are driven,
// popped on each rx_valid/rx_ready handshake.
module tb_uartm_rx;

  localparam int BAUD = 9;
  localparam int BITC = BAUD + 1;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] uartm_baud = 32'(BAUD);
  logic [31:0] uartm_ctl = 32'h0;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    logic        ferr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_hs = 0;
  int   n_ovr = 0;

  uartm_rx dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .RX          (rx),
    .uartm_baud  (uartm_baud),
    .uartm_ctl   (uartm_ctl),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Monitor samples one step after the falling edge, when inputs and outputs are settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      #1;
      if (overrun_err) n_ovr++;
      if (rx_valid && rx_ready) begin
        n_hs++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("rx_data", rx_data, e.data);
          check("parity_err", 32'(parity_err), 32'(e.perr));
          check("frame_err", 32'(frame_err), 32'(e.ferr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge hclk);
  endtask

  task automatic drive_bit(input logic v, input int inv_at);
    for (int j = 0; j < BITC; j++) begin
      @(negedge hclk);
      rx = (j == inv_at) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic stopv, input int glitch_bit);
    drive_bit(1'b0, -1);
    for (int i = 0; i < nbits; i++)
      drive_bit(d[i], (i == glitch_bit) ? BITC / 2 : -1);
    if (pen) drive_bit(pbit, -1);
    drive_bit(stopv, -1);
  endtask

  task automatic push(input logic [31:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge hclk);
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int hs0;
    logic [31:0] w;
    logic [31:0] maj_exp;

    idle(4);
    #1;
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", rx_data, 32'd0);
    check("reset_flags", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    idle(10);

    // 8-bit, no parity
    push(32'h0000_00A5, 1'b0, 1'b0);
    send_frame(32'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    drain("drain_a5");

    // 32-bit even parity, good then flipped parity bit
    uartm_ctl = 32'h0000_000E;
    w = 32'h1234_5678;
    push(w, 1'b0, 1'b0);
    send_frame(w, 32, 1'b1, ^w, 1'b1, -1);
    drain("drain_par_ok");
    push(w, 1'b1, 1'b0);
    send_frame(w, 32, 1'b1, ~(^w), 1'b1, -1);
    drain("drain_par_bad");

    // 16-bit odd parity
    uartm_ctl = 32'h0000_0005;
    w = 32'h0000_BEEF;
    push(w, 1'b0, 1'b0);
    send_frame(w, 16, 1'b1, ~(^w), 1'b1, -1);
    drain("drain_odd");

    // 3-cycle start glitch produces nothing
    uartm_ctl = 32'h0;
    idle(5);
    hs0 = n_hs;
    @(negedge hclk); rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(60);
    check("glitch_no_word", 32'(n_hs), 32'(hs0));

    // low stop bit: word delivered with frame_err, line held low before next frame
    push(32'h0000_005A, 1'b0, 1'b1);
    send_frame(32'h5A, 8, 1'b0, 1'b0, 1'b0, -1);
    idle(30);
    drain("drain_frame_err");
    hs0 = n_hs;
    rx = 1'b1;
    idle(20);
    check("held_low_no_word", 32'(n_hs), 32'(hs0));
    push(32'h0000_0066, 1'b0, 1'b0);
    send_frame(32'h66, 8, 1'b0, 1'b0, 1'b1, -1);
    drain("drain_after_ferr");

    // overrun: second back-to-back frame dropped while first held
    rx_ready = 1'b0;
    hs0 = n_ovr;
    push(32'h0000_0011, 1'b0, 1'b0);
    send_frame(32'h11, 8, 1'b0, 1'b0, 1'b1, -1);
    send_frame(32'h22, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    #1;
    check("ovr_held_data", rx_data, 32'h11);
    check("ovr_held_valid", 32'(rx_valid), 32'd1);
    check("ovr_pulse_count", 32'(n_ovr - hs0), 32'd1);
    @(negedge hclk);
    rx_ready = 1'b1;
    drain("drain_ovr");
    idle(2);
    #1;
    check("ovr_valid_cleared", 32'(rx_valid), 32'd0);

    // reset during data bit 4, with a word held beforehand
    @(negedge hclk);
    rx_ready = 1'b0;
    send_frame(32'h77, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(5);
    w = 32'h3C;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(w[i], -1);
    @(negedge hclk); rx = w[4];
    idle(3);
    hresetn = 1'b0;
    rx = 1'b1;
    idle(3);
    #1;
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_rx_data", rx_data, 32'd0);
    check("midrst_flags", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    rx_ready = 1'b1;
    idle(20);
    #1;
    check("post_rst_idle", 32'(rx_valid), 32'd0);
    push(w, 1'b0, 1'b0);
    send_frame(w, 8, 1'b0, 1'b0, 1'b1, -1);
    drain("drain_3c");

    // single-cycle inverted pulse at the centre of data bit 3
`ifdef UARTM_RX_MAJORITY_EN
    maj_exp = 32'h00;
`else
    maj_exp = 32'h08;
`endif
    push(maj_exp, 1'b0, 1'b0);
    send_frame(32'h00, 8, 1'b0, 1'b0, 1'b1, 3);
    drain("drain_majority");

    idle(20);
    check("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
